// File: rtl/rd_preamble_seq.sv
// Read-capture sequencer: queues read commands, waits out read latency, hunts for the DQS preamble, then opens the capture window.
// Optional feature: define RD_PREAMBLE_SEQ_STATS_EN to add saturating done/err counters.
module rd_preamble_seq #(
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned RL_W      = 6
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic            rd_cmd_valid_i,
    output logic            rd_cmd_ready_o,
    input  logic [RL_W-1:0] rd_cmd_rl_i,
    input  logic            rd_cmd_bl16_i,
    input  logic [2:0]      rd_cmd_pre_i,
    output logic            det_en_o,
    output logic [2:0]      det_pre_amble_sett_o,
    input  logic            pattern_detected_i,
    output logic            capture_en_o,
    output logic            rd_done_o,
    output logic            rd_err_o,
    output logic            busy_o
`ifdef RD_PREAMBLE_SEQ_STATS_EN
    ,
    output logic [15:0]     done_cnt_o,
    output logic [15:0]     err_cnt_o
`endif
);
    localparam int unsigned PTR_W = $clog2(CMD_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = RL_W + 4;
    localparam int unsigned TO_W  = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(CMD_DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT_RL, HUNT, CAPTURE, GAP} state_t;
    state_t state, state_nx;

    logic [ENT_W-1:0] mem [CMD_DEPTH];
    logic [ENT_W-1:0] head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count, count_nx;
    logic             push, pop;

    logic [RL_W-1:0]  lat_cnt, lat_cnt_nx;
    logic [TO_W-1:0]  to_cnt, to_cnt_nx;
    logic [2:0]       win_cnt, win_cnt_nx;
    logic             bl16, bl16_nx;
    logic [2:0]       pre, pre_nx;
    logic             done_nx, err_nx;

    assign head     = mem[rd_ptr];
    assign push     = rd_cmd_valid_i & rd_cmd_ready_o;
    assign count_nx = count + CNT_W'(push) - CNT_W'(pop);
    assign det_pre_amble_sett_o = pre;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {rd_cmd_rl_i, rd_cmd_bl16_i, rd_cmd_pre_i};
        end
    end

    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        to_cnt_nx  = to_cnt;
        win_cnt_nx = win_cnt;
        bl16_nx    = bl16;
        pre_nx     = pre;
        pop        = 1'b0;
        err_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    {lat_cnt_nx, bl16_nx, pre_nx} = head;
                    state_nx = WAIT_RL;
                end
            end
            WAIT_RL: begin
                if (lat_cnt == '0) begin
                    state_nx  = HUNT;
                    to_cnt_nx = '0;
                end else begin
                    lat_cnt_nx = lat_cnt - RL_W'(1);
                end
            end
            HUNT: begin
                to_cnt_nx = to_cnt + TO_W'(1);
                // a detection on the final hunt cycle wins over the timeout
                if (pattern_detected_i) begin
                    state_nx   = CAPTURE;
                    win_cnt_nx = bl16 ? 3'd7 : 3'd3;
                end else if (to_cnt == TO_LAST) begin
                    state_nx = GAP;
                    err_nx   = 1'b1;
                end
            end
            CAPTURE: begin
                if (win_cnt == '0) begin
                    state_nx = GAP;
                end else begin
                    win_cnt_nx = win_cnt - 3'd1;
                end
            end
            GAP:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // registered done must land on the last window cycle, so look one cycle ahead
        done_nx = (state_nx == CAPTURE) && (win_cnt_nx == '0);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            lat_cnt        <= '0;
            to_cnt         <= '0;
            win_cnt        <= '0;
            bl16           <= 1'b0;
            pre            <= '0;
            rd_cmd_ready_o <= 1'b0;
            det_en_o       <= 1'b0;
            capture_en_o   <= 1'b0;
            rd_done_o      <= 1'b0;
            rd_err_o       <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_nx;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count          <= count_nx;
            lat_cnt        <= lat_cnt_nx;
            to_cnt         <= to_cnt_nx;
            win_cnt        <= win_cnt_nx;
            bl16           <= bl16_nx;
            pre            <= pre_nx;
            rd_cmd_ready_o <= (count_nx != FULL);
            det_en_o       <= (state_nx == HUNT);
            capture_en_o   <= (state_nx == CAPTURE);
            rd_done_o      <= done_nx;
            rd_err_o       <= err_nx;
            busy_o         <= (state_nx != IDLE) || (count_nx != '0);
        end
    end

`ifdef RD_PREAMBLE_SEQ_STATS_EN
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            done_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            if (done_nx && (done_cnt_o != '1)) done_cnt_o <= done_cnt_o + 16'd1;
            if (err_nx && (err_cnt_o != '1))   err_cnt_o  <= err_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rd_preamble_seq.sv
// Self-checking bench for rd_preamble_seq: table of single-read vectors plus hand-written FIFO, back-to-back and reset sequences.
module tb_rd_preamble_seq;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       valid;
    logic       ready;
    logic [5:0] rl;
    logic       bl16;
    logic [2:0] pre;
    logic       det_en;
    logic [2:0] det_pre;
    logic       pattern;
    logic       cap;
    logic       done;
    logic       err;
    logic       busy;
`ifdef RD_PREAMBLE_SEQ_STATS_EN
    logic [15:0] done_cnt;
    logic [15:0] err_cnt;
`endif

    int nchk = 0;
    int nerr = 0;
    int gcyc = 0;

    always #5 clk = ~clk;

    rd_preamble_seq #(
        .CMD_DEPTH(4),
        .TIMEOUT  (16),
        .RL_W     (6)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .rd_cmd_valid_i      (valid),
        .rd_cmd_ready_o      (ready),
        .rd_cmd_rl_i         (rl),
        .rd_cmd_bl16_i       (bl16),
        .rd_cmd_pre_i        (pre),
        .det_en_o            (det_en),
        .det_pre_amble_sett_o(det_pre),
        .pattern_detected_i  (pattern),
        .capture_en_o        (cap),
        .rd_done_o           (done),
        .rd_err_o            (err),
        .busy_o              (busy)
`ifdef RD_PREAMBLE_SEQ_STATS_EN
        ,
        .done_cnt_o          (done_cnt),
        .err_cnt_o           (err_cnt)
`endif
    );

    typedef struct {
        logic [5:0] rl;
        logic       bl16;
        logic [2:0] pre;
        int         pulse_at;   // hunt-cycle index of the detector pulse, 99 = never
        bit         spur;       // drive pattern_detected whenever det_en is low
        int         exp_first;  // cycle det_en first high, counted from the accept cycle
        int         exp_hunt;
        int         exp_cap;
        int         exp_done;
        int         exp_err;
        int         exp_end;    // cycle of rd_done or rd_err
    } read_vec_t;

    read_vec_t vecs [6];

    logic [2:0] fpre [5] = '{3'b101, 3'b010, 3'b111, 3'b000, 3'b011};
    logic       fb16 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int         fcap [5] = '{8, 4, 8, 4, 8};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    task automatic push_cmd(input logic [5:0] r, input logic b, input logic [2:0] p);
        logic rdy;
        int   guard = 0;
        valid = 1'b1;
        rl    = r;
        bl16  = b;
        pre   = p;
        do begin
            rdy = ready;
            step();
            guard++;
        end while (!rdy && guard < 100);
        valid = 1'b0;
        chk("push_accept", rdy, 1);
    endtask

    task automatic run_read(input int idx, input read_vec_t v);
        int   cyc = 0, first = -1, hcnt = 0, capn = 0, cap_last = -1;
        int   dcnt = 0, ecnt = 0, end_cyc = -1, idle_cyc = -1;
        bit   pre_bad = 0;
        valid   = 1'b1;
        rl      = v.rl;
        bl16    = v.bl16;
        pre     = v.pre;
        pattern = v.spur;
        while (idle_cyc < 0 && cyc < 200) begin
            step();
            cyc++;
            if (cyc == 1) valid = 1'b0;
            pattern = 1'b0;
            if (det_en) begin
                if (first < 0) first = cyc;
                if (det_pre !== v.pre) pre_bad = 1;
                if (hcnt == v.pulse_at) pattern = 1'b1;
                hcnt++;
            end else if (v.spur) begin
                pattern = 1'b1;
            end
            if (cap) begin
                capn++;
                cap_last = cyc;
            end
            if (done) begin
                dcnt++;
                end_cyc = cyc;
            end
            if (err) begin
                ecnt++;
                end_cyc = cyc;
            end
            if (cyc > 1 && !busy) idle_cyc = cyc;
        end
        pattern = 1'b0;
        chk($sformatf("v%0d_det_first", idx), first, v.exp_first);
        chk($sformatf("v%0d_det_cycles", idx), hcnt, v.exp_hunt);
        chk($sformatf("v%0d_cap_cycles", idx), capn, v.exp_cap);
        chk($sformatf("v%0d_done", idx), dcnt, v.exp_done);
        chk($sformatf("v%0d_err", idx), ecnt, v.exp_err);
        chk($sformatf("v%0d_end_cycle", idx), end_cyc, v.exp_end);
        chk($sformatf("v%0d_pre_stable", idx), pre_bad, 0);
        chk($sformatf("v%0d_idle_cycle", idx), idle_cyc, v.exp_end + (v.exp_err != 0 ? 1 : 2));
        if (v.exp_done != 0) chk($sformatf("v%0d_done_last_cap", idx), cap_last, end_cyc);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    initial begin
        logic       prev;
        logic [2:0] seen [5];
        int         caps [5];
        int         nd, ne, nr, clen, guard, hi, base, lowc, capt, cc;
        int         rise [2];
        int         dn [2];

        vecs[0] = '{6'd5,  1'b0, 3'b001, 5,  1'b0, 8,  6,  4, 1, 0, 17};
        vecs[1] = '{6'd0,  1'b1, 3'b110, 0,  1'b0, 3,  1,  8, 1, 0, 11};
        vecs[2] = '{6'd3,  1'b0, 3'b111, 99, 1'b0, 6,  16, 0, 0, 1, 22};
        vecs[3] = '{6'd1,  1'b1, 3'b010, 15, 1'b0, 4,  16, 8, 1, 0, 27};
        vecs[4] = '{6'd63, 1'b0, 3'b100, 2,  1'b0, 66, 3,  4, 1, 0, 72};
        vecs[5] = '{6'd4,  1'b0, 3'b011, 2,  1'b1, 7,  3,  4, 1, 0, 13};

        reset_n = 1'b0;
        valid   = 1'b0;
        rl      = '0;
        bl16    = 1'b0;
        pre     = '0;
        pattern = 1'b0;
        repeat (3) step();
        chk("rst_ready", ready, 0);
        chk("rst_det_en", det_en, 0);
        chk("rst_det_pre", det_pre, 0);
        chk("rst_cap", cap, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        reset_n = 1'b1;
        chk("rel_ready_pre_edge", ready, 0);
        step();
        chk("rel_ready", ready, 1);
        chk("rel_busy", busy, 0);

        for (int i = 0; i < 6; i++) run_read(i, vecs[i]);

        // FIFO fill while the first read sits in a long read latency
        for (int k = 0; k < 5; k++) push_cmd(6'd40, fb16[k], fpre[k]);
        chk("fifo_full_ready", ready, 0);
        chk("fifo_full_busy", busy, 1);
        hi    = 0;
        valid = 1'b1;
        rl    = 6'd0;
        bl16  = 1'b0;
        pre   = 3'b110;
        for (int k = 0; k < 6; k++) begin
            if (ready) hi++;
            step();
        end
        valid = 1'b0;
        chk("fifo_ready_held_low", hi, 0);
        nd = 0; ne = 0; nr = 0; clen = 0; guard = 0; prev = 1'b0;
        for (int k = 0; k < 5; k++) begin
            seen[k] = 3'b000;
            caps[k] = 0;
        end
        while ((nd < 5 || busy) && guard < 1000) begin
            pattern = det_en && !prev;
            if (det_en && !prev && nr < 5) begin
                seen[nr] = det_pre;
                nr++;
            end
            prev = det_en;
            if (cap) clen++;
            if (done) begin
                if (nd < 5) caps[nd] = clen;
                nd++;
                clen = 0;
            end
            if (err) ne++;
            step();
            guard++;
        end
        pattern = 1'b0;
        chk("fifo_drain_in_budget", guard < 1000, 1);
        chk("fifo_done_count", nd, 5);
        chk("fifo_err_count", ne, 0);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fifo_pre_%0d", k), seen[k], fpre[k]);
            chk($sformatf("fifo_cap_%0d", k), caps[k], fcap[k]);
        end

        // back-to-back BL16 reads with zero read latency
        base = gcyc;
        push_cmd(6'd0, 1'b1, 3'b110);
        push_cmd(6'd0, 1'b1, 3'b001);
        nr = 0; nd = 0; capt = 0; lowc = 0; guard = 0; prev = 1'b0;
        rise[0] = -1; rise[1] = -1; dn[0] = -1; dn[1] = -1;
        seen[0] = 3'b000; seen[1] = 3'b000;
        while ((nd < 2 || busy) && guard < 200) begin
            pattern = det_en && !prev;
            if (det_en && !prev && nr < 2) begin
                rise[nr] = gcyc - base;
                seen[nr] = det_pre;
                nr++;
            end
            if (!det_en && nr == 1) lowc++;
            prev = det_en;
            if (cap) capt++;
            if (done) begin
                if (nd < 2) dn[nd] = gcyc - base;
                nd++;
            end
            step();
            guard++;
        end
        pattern = 1'b0;
        chk("b2b_rise0", rise[0], 3);
        chk("b2b_rise1", rise[1], 15);
        chk("b2b_done0", dn[0], 11);
        chk("b2b_done1", dn[1], 23);
        chk("b2b_cap_total", capt, 16);
        chk("b2b_det_low_gap", lowc >= 1, 1);
        chk("b2b_pre0", seen[0], 3'b110);
        chk("b2b_pre1", seen[1], 3'b001);
`ifdef RD_PREAMBLE_SEQ_STATS_EN
        chk("stats_done_cnt", done_cnt, 12);
        chk("stats_err_cnt", err_cnt, 1);
`endif

        // reset in the middle of a capture window, with a second read still queued
        push_cmd(6'd0, 1'b1, 3'b101);
        push_cmd(6'd0, 1'b1, 3'b010);
        cc = 0; guard = 0; prev = 1'b0;
        forever begin
            pattern = det_en && !prev;
            prev = det_en;
            if (cap) cc++;
            if (cc >= 2 || guard >= 100) break;
            step();
            guard++;
        end
        pattern = 1'b0;
        chk("mid_cap_reached", cc, 2);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cap", cap, 0);
        chk("mid_rst_det_en", det_en, 0);
        chk("mid_rst_det_pre", det_pre, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 0);
        repeat (2) step();
        reset_n = 1'b1;
        step();
        chk("post_rst_ready", ready, 1);
        chk("post_rst_busy", busy, 0);
        hi = 0;
        for (int k = 0; k < 30; k++) begin
            if (det_en || cap || done || err || busy) hi++;
            step();
        end
        chk("post_rst_quiet", hi, 0);
`ifdef RD_PREAMBLE_SEQ_STATS_EN
        chk("post_rst_done_cnt", done_cnt, 0);
        chk("post_rst_err_cnt", err_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/rd_preamble_seq.md
# rd_preamble_seq

Read-capture sequencer for the Data Manager read path. Accepts read commands from the PHY command layer, buffers them in a small FIFO, and runs each read in turn. For each read it waits out the read latency, enables the DQS preamble detector with the command's preamble setting, and opens a data-capture window of burst length once the preamble is found. It also flags a timeout when no preamble arrives. It sits between the read command scheduler and the pattern detector / DQ capture logic.

## Interface
- CMD_DEPTH, 4: command FIFO entries (power of 2, ≥2)
- TIMEOUT, 16: max cycles in HUNT before error (≥4)
- RL_W, 6: width of read-latency field
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- rd_cmd_valid_i  in  1  read command valid
- rd_cmd_ready_o  out  1  FIFO not full
- rd_cmd_rl_i  in  RL_W  cycles from dequeue to detector enable
- rd_cmd_bl16_i  in  1  1=BL16 (8-cycle window), 0=BL8 (4-cycle window)
- rd_cmd_pre_i  in  3  preamble setting for this read
- det_en_o  out  1  detector enable
- det_pre_amble_sett_o  out  3  preamble setting to detector
- pattern_detected_i  in  1  single-cycle detector pulse
- capture_en_o  out  1  DQ capture window
- rd_done_o  out  1  pulse, read captured
- rd_err_o  out  1  pulse, preamble timeout
- busy_o  out  1  FSM not IDLE or FIFO not empty

## Operation
- FIFO: a command is written when valid&ready. Each entry stores {rl, bl16, pre}. A write to a full FIFO is impossible (ready=0). Simultaneous push and pop are allowed when full, but ready is still computed from the registered count, so it stays 0 that cycle.
- FSM states: IDLE, WAIT_RL, HUNT, CAPTURE, GAP.
- IDLE: if FIFO not empty, pop the head and latch rl/bl16/pre into working registers, load lat_cnt=rl, then go to WAIT_RL.
- WAIT_RL: decrement lat_cnt. When lat_cnt==0, go to HUNT and clear to_cnt. rl=0 leaves WAIT_RL after one cycle.
- HUNT: det_en_o=1. to_cnt increments each cycle.
  - pattern_detected_i=1: go to CAPTURE and load win_cnt = bl16 ? 7 : 3.
  - Otherwise, when to_cnt==TIMEOUT-1: pulse rd_err_o and go to GAP.
  - A pulse and timeout in the same cycle count as a detection.
- CAPTURE: capture_en_o=1 and det_en_o=0. win_cnt decrements. At win_cnt==0, pulse rd_done_o and go to GAP.
- GAP: one cycle with det_en_o=0, guaranteeing detector reset between reads. Then go to IDLE.
- pattern_detected_i outside HUNT is ignored.
- det_pre_amble_sett_o holds the latched pre of the active read. It is stable from WAIT_RL entry through GAP and is 3'b000 after reset.
- Reset mid-operation: FIFO is flushed, FSM goes to IDLE, and all outputs return to reset values. No done/err pulse is issued for aborted reads.

## Timing
- All outputs are registered. Reset values:
  - det_en_o=0, det_pre_amble_sett_o=0, capture_en_o=0, rd_done_o=0, rd_err_o=0, busy_o=0
  - rd_cmd_ready_o=1 one cycle after reset release (0 during reset)
- Accept at cycle T with empty FIFO and IDLE FSM: pop at T+1, WAIT_RL from T+2, det_en_o high from T+2+rl+1.
- Pulse sampled in HUNT at cycle D:
  - capture_en_o high D+1..D+4 (BL8) or D+1..D+8 (BL16)
  - rd_done_o one cycle, coincident with the last capture_en_o cycle
- Timeout: det_en_o high for exactly TIMEOUT cycles, then rd_err_o pulses for 1 cycle.
- Back-to-back reads: minimum 2 cycles (GAP + IDLE) between one read's final capture cycle and the next WAIT_RL.

## Configuration
- RD_PREAMBLE_SEQ_STATS_EN defined: adds outputs done_cnt_o[15:0] and err_cnt_o[15:0]. They are saturating counts of rd_done_o and rd_err_o pulses, reset to 0, and saturate at 16'hFFFF.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Test plan
- Single BL8 read, rl=5, pre=3'b001, detector pulse after 6 HUNT cycles -> det_pre_amble_sett_o=001, capture_en_o high 4 cycles, one rd_done_o, rd_err_o=0.
- No pulse, TIMEOUT=16 -> det_en_o high exactly 16 cycles, one rd_err_o, FSM back to IDLE, busy_o=0.
- Push 5 commands with CMD_DEPTH=4 and FSM stalled in WAIT_RL (rl=40) -> rd_cmd_ready_o=0 after the FIFO fills. All accepted reads complete in order with their own pre/bl16 values.
- Back-to-back BL16 reads, rl=0 -> det_en_o low for at least 1 cycle between reads, 8-cycle windows, two rd_done_o pulses.
- Spurious pattern_detected_i during WAIT_RL and CAPTURE -> ignored, with no window extension or early capture.
- reset_n_i asserted mid-CAPTURE -> capture_en_o=0 immediately, FIFO empty, no rd_done_o. With RD_PREAMBLE_SEQ_STATS_EN defined, the counters read 0.
